// File: rtl/rrf_alloc_ctrl_pkg.sv
// Shared constants and small helpers for the rename/ROB entry allocator.
package rrf_alloc_ctrl_pkg;

  localparam int RRF_NUM_DEF = 64;

  typedef logic [1:0] cnt2_t;

  function automatic cnt2_t alloc_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/rrf_alloc_ctrl_chk.sv
// Protocol checker for rrf_alloc_ctrl: illegal request/commit patterns and
// free-count range.
module rrf_alloc_ctrl_chk #(
  parameter int RRF_NUM = 64,
  parameter int RRF_SEL = 6
) (
  input logic             i_clk,
  input logic             i_reset,
  input logic             i_req1,
  input logic             i_req2,
  input logic [1:0]       i_comnum,
  input logic [RRF_SEL:0] i_freenum
);

  logic [RRF_SEL:0] w_occupancy;

  assign w_occupancy = (RRF_SEL+1)'(RRF_NUM) - i_freenum;

  a_req2_without_req1: assert property (@(posedge i_clk) disable iff (i_reset)
    !(i_req2 && !i_req1))
    else $error("rrf_alloc_ctrl: req2 asserted without req1");

  a_comnum_legal: assert property (@(posedge i_clk) disable iff (i_reset)
    i_comnum != 2'd3)
    else $error("rrf_alloc_ctrl: comnum of 3");

  a_comnum_le_occ: assert property (@(posedge i_clk) disable iff (i_reset)
    (RRF_SEL+1)'(i_comnum) <= w_occupancy)
    else $error("rrf_alloc_ctrl: commit exceeds occupancy");

  a_freenum_range: assert property (@(posedge i_clk) disable iff (i_reset)
    i_freenum <= (RRF_SEL+1)'(RRF_NUM))
    else $error("rrf_alloc_ctrl: freenum above ring size");

endmodule

// File: rtl/rrf_ring_ptr.sv
// Ring pointer: RRF_SEL-wide index with synchronous reset, optional load,
// and a 0..2 advance that wraps naturally because the ring is a power of two.
module rrf_ring_ptr
  import rrf_alloc_ctrl_pkg::*;
#(
  parameter int RRF_SEL = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [RRF_SEL-1:0] i_load_val,
  input  cnt2_t              i_inc,
  output logic [RRF_SEL-1:0] o_ptr
);

  logic [RRF_SEL-1:0] r_ptr;

  // Pointer register: reset, load on rollback, otherwise advance by i_inc.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= {RRF_SEL{1'b0}};
    end else if (i_load) begin
      r_ptr <= i_load_val;
    end else begin
      r_ptr <= r_ptr + RRF_SEL'(i_inc);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/rrf_alloc_ctrl.sv
// Rename/ROB entry allocator: grants up to two ring entries per cycle and
// reclaims them on commit. Define RRF_ALLOC_ROLLBACK_EN to flush on prmiss_i.
module rrf_alloc_ctrl
  import rrf_alloc_ctrl_pkg::*;
#(
  parameter int RRF_NUM = RRF_NUM_DEF,
  parameter int RRF_SEL = $clog2(RRF_NUM)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               req1_i,
  input  logic               req2_i,
  input  logic               stall_ext_i,
  input  logic [1:0]         comnum_i,
  input  logic               prmiss_i,
  output logic               dp1_o,
  output logic [RRF_SEL-1:0] dp1_addr_o,
  output logic               dp2_o,
  output logic [RRF_SEL-1:0] dp2_addr_o,
  output logic [RRF_SEL-1:0] dispatch_ptr_o,
  output logic [RRF_SEL-1:0] commit_ptr_o,
  output logic [RRF_SEL:0]   rrf_freenum_o,
  output logic               stall_o
);

  localparam logic [RRF_SEL:0] LP_FREE_FULL = (RRF_SEL+1)'(RRF_NUM);

  logic [RRF_SEL-1:0] w_dispatch_ptr;
  logic [RRF_SEL-1:0] w_commit_ptr;
  logic [RRF_SEL-1:0] w_disp_load_val;
  logic [RRF_SEL:0]   r_freenum;
  logic [RRF_SEL:0]   w_freenum_next;
  logic               w_rollback;
  logic               w_stall;
  logic               w_dp1;
  logic               w_dp2;
  cnt2_t              w_allocnum;

`ifdef RRF_ALLOC_ROLLBACK_EN
  // On a flush the dispatch pointer snaps to the post-commit head of the ring.
  assign w_rollback      = prmiss_i;
  assign w_disp_load_val = w_commit_ptr + RRF_SEL'(comnum_i);
`else
  logic w_unused_prmiss;
  assign w_unused_prmiss = prmiss_i;
  assign w_rollback      = 1'b0;
  assign w_disp_load_val = {RRF_SEL{1'b0}};
`endif

  // Grant/stall decision, all-or-nothing per pair, from the registered free count.
  always_comb begin
    w_stall    = reset_i | stall_ext_i | w_rollback
               | (req1_i & (r_freenum == {(RRF_SEL+1){1'b0}}))
               | (req2_i & (r_freenum < (RRF_SEL+1)'(2)));
    w_dp1      = req1_i & ~w_stall;
    w_dp2      = req2_i & req1_i & ~w_stall;
    w_allocnum = alloc_count(w_dp1, w_dp2);
  end

  // Free-count next state: net of allocations and commits, full on rollback.
  always_comb begin
    w_freenum_next = r_freenum;
    if (w_rollback) begin
      w_freenum_next = LP_FREE_FULL;
    end else begin
      w_freenum_next = r_freenum - (RRF_SEL+1)'(w_allocnum) + (RRF_SEL+1)'(comnum_i);
    end
  end

  // Free-count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_freenum <= LP_FREE_FULL;
    end else begin
      r_freenum <= w_freenum_next;
    end
  end

  rrf_ring_ptr #(.RRF_SEL(RRF_SEL)) u_dispatch_ptr (
    .i_clk      (clk_i),
    .i_reset    (reset_i),
    .i_load     (w_rollback),
    .i_load_val (w_disp_load_val),
    .i_inc      (w_allocnum),
    .o_ptr      (w_dispatch_ptr)
  );

  rrf_ring_ptr #(.RRF_SEL(RRF_SEL)) u_commit_ptr (
    .i_clk      (clk_i),
    .i_reset    (reset_i),
    .i_load     (1'b0),
    .i_load_val ({RRF_SEL{1'b0}}),
    .i_inc      (comnum_i),
    .o_ptr      (w_commit_ptr)
  );

  rrf_alloc_ctrl_chk #(.RRF_NUM(RRF_NUM), .RRF_SEL(RRF_SEL)) u_chk (
    .i_clk     (clk_i),
    .i_reset   (reset_i),
    .i_req1    (req1_i),
    .i_req2    (req2_i),
    .i_comnum  (comnum_i),
    .i_freenum (r_freenum)
  );

  assign dp1_o          = w_dp1;
  assign dp2_o          = w_dp2;
  assign dp1_addr_o     = w_dispatch_ptr;
  assign dp2_addr_o     = w_dispatch_ptr + RRF_SEL'(1'b1);
  assign dispatch_ptr_o = w_dispatch_ptr;
  assign commit_ptr_o   = w_commit_ptr;
  assign rrf_freenum_o  = r_freenum;
  assign stall_o        = w_stall;

endmodule
